// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution over a raster-order frame: two line buffers feed a
// 3x3 window, a 9-tap signed MAC adds bias, then saturate and optional ReLU.
module conv3x3_stream #(
  parameter int DATA_WIDTH   = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int OUT_WIDTH    = 20,
  parameter int IMG_WIDTH    = 28,
  parameter int IMG_HEIGHT   = 28,
  parameter int RELU         = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           enable,
  input  logic signed [DATA_WIDTH-1:0]   data_in,
  input  logic                           valid_in,
  input  logic [9*WEIGHT_WIDTH-1:0]      weights,
  input  logic signed [OUT_WIDTH-1:0]    bias,
  output logic signed [OUT_WIDTH-1:0]    data_out,
  output logic                           valid_out,
  output logic                           frame_done
);

  localparam int CW    = (IMG_WIDTH  > 2) ? $clog2(IMG_WIDTH)  : 2;
  localparam int RW    = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 2;
  localparam int PW    = DATA_WIDTH + WEIGHT_WIDTH;
  localparam int SUM_A = DATA_WIDTH + WEIGHT_WIDTH + 4;
  localparam int SUM_W = ((SUM_A > OUT_WIDTH) ? SUM_A : OUT_WIDTH) + 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  localparam logic signed [SUM_W-1:0] SAT_MAX =
    $signed({{(SUM_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}});
  localparam logic signed [SUM_W-1:0] SAT_MIN =
    $signed({{(SUM_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}});

  logic [CW-1:0]                  r_col;
  logic [RW-1:0]                  r_row;
  logic signed [DATA_WIDTH-1:0]   r_lb1 [IMG_WIDTH];
  logic signed [DATA_WIDTH-1:0]   r_lb2 [IMG_WIDTH];
  logic signed [DATA_WIDTH-1:0]   r_win [9];

  logic                           w_accept;
  logic                           w_col_last;
  logic                           w_row_last;
  logic                           w_in_window;
  logic signed [DATA_WIDTH-1:0]   w_win_nxt [9];
  logic signed [PW-1:0]           w_prod [9];
  logic signed [SUM_W-1:0]        w_sum;
  logic signed [OUT_WIDTH-1:0]    w_sat;
  logic signed [OUT_WIDTH-1:0]    w_result;

  assign w_accept    = enable & valid_in;
  assign w_col_last  = (r_col == COL_LAST);
  assign w_row_last  = (r_row == ROW_LAST);
  assign w_in_window = (r_row >= RW'(2)) && (r_col >= CW'(2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // Line buffers are deliberately not reset; rows 0/1 of a frame never emit.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lb2[r_col] <= r_lb1[r_col];
      r_lb1[r_col] <= data_in;
    end
  end

  always_comb begin
    for (int ky = 0; ky < 3; ky++) begin
      w_win_nxt[3*ky]   = r_win[3*ky+1];
      w_win_nxt[3*ky+1] = r_win[3*ky+2];
    end
    w_win_nxt[2] = r_lb2[r_col];
    w_win_nxt[5] = r_lb1[r_col];
    w_win_nxt[8] = data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 9; k++) r_win[k] <= '0;
    end else if (w_accept) begin
      for (int k = 0; k < 9; k++) r_win[k] <= w_win_nxt[k];
    end
  end

  // MAC runs on the post-shift window so the result is ready at the accepting edge.
  always_comb begin
    w_sum = SUM_W'(bias);
    for (int k = 0; k < 9; k++) begin
      w_prod[k] = PW'(w_win_nxt[k]) * PW'($signed(weights[k*WEIGHT_WIDTH +: WEIGHT_WIDTH]));
      w_sum     = w_sum + SUM_W'(w_prod[k]);
    end
  end

  always_comb begin
    if (w_sum > SAT_MAX) begin
      w_sat = SAT_MAX[OUT_WIDTH-1:0];
    end else if (w_sum < SAT_MIN) begin
      w_sat = SAT_MIN[OUT_WIDTH-1:0];
    end else begin
      w_sat = w_sum[OUT_WIDTH-1:0];
    end
    w_result = w_sat;
    if ((RELU != 0) && w_sat[OUT_WIDTH-1]) w_result = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out   <= '0;
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      if (w_accept && w_in_window) begin
        valid_out  <= 1'b1;
        data_out   <= w_result;
        frame_done <= w_col_last && w_row_last;
      end
    end
  end

endmodule
